// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID check master: FSM states, word offsets,
// data width and the default expected ID/timestamp values.
package sysid_pkg;

    localparam int SYSID_DATA_W  = 32;
    localparam int SYSID_WORD_ID = 0;
    localparam int SYSID_WORD_TS = 1;

    localparam logic [SYSID_DATA_W-1:0] SYSID_DEF_ID = 32'h0000_0000;
    localparam logic [SYSID_DATA_W-1:0] SYSID_DEF_TS = 32'd1647018338;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_EVAL  = 3'd3,
        ST_FIN   = 3'd4,
        ST_RETRY = 3'd5
    } sysid_state_e;

    // Byte address of a 32-bit word relative to the slave base.
    function automatic int word_addr(input int base, input int word);
        return base + (word * 4);
    endfunction

endpackage

// File: rtl/sysid_read_timer.sv
// Per-transaction stall counter; o_expired flags the last allowed stall cycle.
module sysid_read_timer #(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [15:0] r_count;

    // Count stall cycles; clear has priority so each read starts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (i_clear) begin
            r_count <= 16'd0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end else begin
            r_count <= r_count;
        end
    end

    // The LIMIT-th consecutive stall cycle is the last one tolerated.
    assign o_expired = i_enable && (r_count == 16'(LIMIT - 1));

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and
// checks them. Optional macro SYSID_RETRY_EN enables retries and retry_count.
module sysid_check_master
    import sysid_pkg::*;
#(
    parameter int                       ADDR_W         = 4,
    parameter int                       BASE_ADDR      = 0,
    parameter logic [SYSID_DATA_W-1:0]  EXPECTED_ID    = SYSID_DEF_ID,
    parameter logic [SYSID_DATA_W-1:0]  EXPECTED_TS    = SYSID_DEF_TS,
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter int                       MAX_RETRIES    = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic [ADDR_W-1:0]        avm_address,
    output logic                     avm_read,
    input  logic                     avm_waitrequest,
    input  logic [SYSID_DATA_W-1:0]  avm_readdata,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout_err,
`ifdef SYSID_RETRY_EN
    output logic [3:0]               retry_count,
`endif
    output logic [SYSID_DATA_W-1:0]  id_value,
    output logic [SYSID_DATA_W-1:0]  ts_value
);

    localparam logic [ADDR_W-1:0] ADDR_ID = ADDR_W'(word_addr(BASE_ADDR, SYSID_WORD_ID));
    localparam logic [ADDR_W-1:0] ADDR_TS = ADDR_W'(word_addr(BASE_ADDR, SYSID_WORD_TS));

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end
    if ((MAX_RETRIES < 1) || (MAX_RETRIES > 15)) begin : g_bad_retries
        $error("MAX_RETRIES out of range 1..15");
    end

    sysid_state_e              r_state;
    logic                      r_auto;
    logic                      r_read;
    logic [ADDR_W-1:0]         r_addr;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_pass;
    logic                      r_timeout;
    logic [SYSID_DATA_W-1:0]   r_id;
    logic [SYSID_DATA_W-1:0]   r_ts;
`ifdef SYSID_RETRY_EN
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);
    logic [3:0]                r_retry;
`endif

    logic w_go;
    logic w_in_read;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_expired;
    logic w_match;

    // r_auto makes the first cycle out of reset behave like a start pulse.
    assign w_go          = start || r_auto;
    assign w_in_read     = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
    assign w_timer_clear = !w_in_read || !avm_waitrequest;
    assign w_timer_en    = w_in_read && avm_waitrequest;
    assign w_match       = (r_id == EXPECTED_ID) && (r_ts == EXPECTED_TS);

    sysid_read_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    // Check sequencer: all Avalon and status outputs are registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_auto    <= 1'b1;
            r_read    <= 1'b0;
            r_addr    <= ADDR_ID;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_id      <= 32'h0000_0000;
            r_ts      <= 32'h0000_0000;
`ifdef SYSID_RETRY_EN
            r_retry   <= 4'd0;
`endif
        end else begin
            r_auto <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_busy    <= 1'b1;
                        r_read    <= 1'b1;
                        r_addr    <= ADDR_ID;
                        r_state   <= ST_RD_ID;
`ifdef SYSID_RETRY_EN
                        r_retry   <= 4'd0;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_ID, ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        if (r_state == ST_RD_ID) begin
                            // avm_read stays high: the TS read follows back-to-back.
                            r_id    <= avm_readdata;
                            r_addr  <= ADDR_TS;
                            r_state <= ST_RD_TS;
                        end else begin
                            r_ts    <= avm_readdata;
                            r_read  <= 1'b0;
                            r_state <= ST_EVAL;
                        end
                    end else if (w_expired) begin
                        r_read <= 1'b0;
`ifdef SYSID_RETRY_EN
                        if (r_retry < RETRY_LIMIT) begin
                            r_retry <= r_retry + 4'd1;
                            r_state <= ST_RETRY;
                        end else begin
                            r_timeout <= 1'b1;
                            r_pass    <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= ST_FIN;
                        end
`else
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_FIN;
`endif
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_EVAL: begin
`ifdef SYSID_RETRY_EN
                    // EVAL already has avm_read low, so it serves as the idle gap.
                    if (!w_match && (r_retry < RETRY_LIMIT)) begin
                        r_retry <= r_retry + 4'd1;
                        r_read  <= 1'b1;
                        r_addr  <= ADDR_ID;
                        r_state <= ST_RD_ID;
                    end else begin
                        r_pass  <= w_match;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end
`else
                    r_pass  <= w_match;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_FIN;
`endif
                end
`ifdef SYSID_RETRY_EN
                ST_RETRY: begin
                    r_read  <= 1'b1;
                    r_addr  <= ADDR_ID;
                    r_state <= ST_RD_ID;
                end
`endif
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_read  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign avm_address = r_addr;
    assign avm_read    = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout_err = r_timeout;
    assign id_value    = r_id;
    assign ts_value    = r_ts;
`ifdef SYSID_RETRY_EN
    assign retry_count = r_retry;
`endif

endmodule
